// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I constants and types for the front end.
//   - XLEN / INSTR_W   : address and instruction widths (32 only)
//   - NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown on an empty output
//   - PC_STEP          : sequential fetch increment
//   - *_W              : instruction field widths used by the field-decode stage
//   - fetch_pair_t     : {pc, instr} pair carried across the IF/ID boundary
//   - word_align()     : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;

  localparam int OPCODE_W = 7;
  localparam int RD_W     = 5;
  localparam int FUNCT3_W = 3;
  localparam int RS1_W    = 5;
  localparam int RS2_W    = 5;
  localparam int FUNCT7_W = 7;
  localparam int IMM_I_W  = 12;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pair_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(PC_STEP - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
//   One-entry holding register for a {pc, instr} pair. Catches the single
//   response that is already in flight when the consumer stalls.
//
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; empties the buffer
//   flush      in   empties the buffer (dominates push)
//   push       in   write push_data; valid afterwards
//   push_data  in   pair to store
//   pop        in   consumer took the stored pair; empty afterwards
//   valid      out  buffer holds a pair
//   data       out  stored pair
//
//   push and pop in the same cycle replace the entry and keep valid set.
// -----------------------------------------------------------------------------
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  fetch_pair_t push_data,
  input  logic        pop,
  output logic        valid,
  output fetch_pair_t data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   RV32I fetch stage. Owns the PC, issues word reads to a synchronous
//   instruction memory (1-cycle latency) and registers each {pc, instr} pair
//   for the decode stage behind a valid/ready handshake. A one-entry skid
//   buffer absorbs the response that is in flight when decode stalls.
//   Redirects from EX flush everything in flight and restart at the target.
//
//   Parameters
//     XLEN      data/address width (only 32 supported)
//     RESET_PC  PC after reset (4-byte aligned)
//
//   Ports
//     clk          in   clock, rising edge
//     reset        in   synchronous, active-high
//     imem_en      out  read request this cycle
//     imem_addr    out  byte address of request (= pc_q, [1:0]=00)
//     imem_rdata   in   word for the previous cycle's request
//     redirect     in   taken branch/jump: flush and refetch
//     redirect_pc  in   new PC, [1:0] ignored
//     out_valid    out  out_pc/out_instr hold a valid pair
//     out_ready    in   decode accepts when out_valid & out_ready
//     out_pc       out  address of out_instr
//     out_instr    out  raw instruction word
//
//   State is pc_q, inflight_q, skid valid and out_valid; there is no FSM.
//   Latency from issue to out_* is two cycles; throughput one per cycle.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  import riscv_pkg::*;

  logic [XLEN-1:0]    pc_q;
  logic               inflight_q;
  logic [XLEN-1:0]    inflight_pc_q;

  logic               out_valid_q;
  logic [XLEN-1:0]    out_pc_q;
  logic [INSTR_W-1:0] out_instr_q;

  logic               skid_valid;
  fetch_pair_t        skid_data;

  logic               out_free;
  logic               resp_valid;
  logic               load_out;
  logic               skid_push;
  logic               skid_pop;
  fetch_pair_t        resp_pair;
  fetch_pair_t        out_next;

  // Issuing is blocked whenever a stored pair is waiting, so at most one
  // response can ever be outstanding beyond the output register.
  assign imem_en   = !reset && !redirect && !skid_valid && (out_ready || !out_valid_q);
  assign imem_addr = pc_q;

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  always_comb begin
    out_free        = !out_valid_q || out_ready;
    // A response arriving in a redirect cycle belongs to the old path.
    resp_valid      = inflight_q && !redirect;
    resp_pair.pc    = inflight_pc_q;
    resp_pair.instr = imem_rdata;
    load_out        = out_free && (skid_valid || resp_valid);
    skid_pop        = out_free && skid_valid;
    // Older skid entry goes out first; a simultaneous response takes its place.
    skid_push       = resp_valid && (!out_free || skid_valid);
    out_next        = skid_valid ? skid_data : resp_pair;
  end

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (skid_push),
    .push_data (resp_pair),
    .pop       (skid_pop),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= word_align(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= NOP_INSTR;
    end else if (redirect) begin
      pc_q        <= word_align(redirect_pc);
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (imem_en) begin
        pc_q          <= pc_q + PC_STEP;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q <= 1'b0;
      end

      if (load_out) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= out_next.pc;
        out_instr_q <= out_next.instr;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b1;

  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic        b_redirect = 1'b0;
  logic [31:0] b_redirect_pc = 32'h0;
  logic        b_ready = 1'b1;
  logic        b_imem_en;
  logic [31:0] b_imem_addr;
  logic [31:0] b_imem_rdata = 32'hDEAD_BEEF;
  logic        b_out_valid;
  logic [31:0] b_out_pc;
  logic [31:0] b_out_instr;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_en(b_imem_en), .imem_addr(b_imem_addr),
    .imem_rdata(b_imem_rdata), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .out_valid(b_out_valid), .out_ready(b_ready), .out_pc(b_out_pc), .out_instr(b_out_instr)
  );

  always #5 clk = ~clk;

  // Memory image: word at byte address a is 0x11 + a/4 (0x11..0x15 at 0x0..0x10).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h11 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= mem_word(imem_addr);
    if (b_imem_en) b_imem_rdata <= mem_word(b_imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected PC stream, refilled whenever reset/redirect is driven.
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;

  task automatic sb_reload(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(start + 32'(i) * 32'd4);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h with no expected entry", out_pc);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_pc", out_pc, sb_exp);
        chk("sb_instr", out_instr, mem_word(sb_exp));
      end
    end
    if (reset)         sb_reload(32'h0);
    else if (redirect) sb_reload(redirect_pc & ~32'd3);
  end

  // Wrap instance: record the first three delivered PCs.
  logic [31:0] b_seen[$];
  always @(negedge clk) begin
    if (!reset && b_out_valid && b_seen.size() < 3) begin
      b_seen.push_back(b_out_pc);
      chk("wrap_instr", b_out_instr, mem_word(b_out_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [31:0] first_pc;
    logic        two;
    logic [31:0] pc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t  tbl[5];
  logic [31:0] b_exp[3];

  initial begin
    tbl[0] = '{32'h0000_0000, 1'b0, 32'h0000_0040, 32'h0000_0040};
    tbl[1] = '{32'h0000_0000, 1'b0, 32'h0000_0103, 32'h0000_0100};
    tbl[2] = '{32'h0000_0500, 1'b1, 32'h0000_0202, 32'h0000_0200};
    tbl[3] = '{32'h0000_0000, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFC};
    tbl[4] = '{32'h0000_0010, 1'b1, 32'h0000_0007, 32'h0000_0004};
    b_exp[0] = 32'hFFFF_FFF8;
    b_exp[1] = 32'hFFFF_FFFC;
    b_exp[2] = 32'h0000_0000;

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, NOP_INSTR);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Streaming after reset release
    reset = 1'b0;
    #1;
    chk("s1_valid0", 32'(out_valid), 32'd0);
    chk("s1_en0", 32'(imem_en), 32'd1);
    chk("s1_addr0", imem_addr, 32'h0);
    tick(); #1;
    chk("s1_valid1", 32'(out_valid), 32'd0);
    chk("s1_addr1", imem_addr, 32'h4);
    tick(); #1;
    chk("s1_valid2", 32'(out_valid), 32'd1);
    chk("s1_pc2", out_pc, 32'h0);
    chk("s1_instr2", out_instr, 32'h11);
    tick(); #1;
    chk("s1_pc3", out_pc, 32'h4);
    chk("s1_instr3", out_instr, 32'h12);
    repeat (3) tick();

    // Stall for three cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_en", 32'(imem_en), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, sb_q[0]);
      chk("stall_instr", out_instr, mem_word(sb_q[0]));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("drain_en", 32'(imem_en), 32'd0);
    repeat (6) tick();

    // Redirect vectors (including in-flight discard, misaligned and back-to-back)
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].two) begin
        redirect = 1'b1;
        redirect_pc = tbl[i].first_pc;
        tick();
      end
      redirect = 1'b1;
      redirect_pc = tbl[i].pc;
      #1;
      chk("rd_en", 32'(imem_en), 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("rd_valid1", 32'(out_valid), 32'd0);
      chk("rd_addr", imem_addr, tbl[i].exp_addr);
      chk("rd_en1", 32'(imem_en), 32'd1);
      tick(); #1;
      chk("rd_valid2", 32'(out_valid), 32'd0);
      tick(); #1;
      chk("rd_valid3", 32'(out_valid), 32'd1);
      chk("rd_pc", out_pc, tbl[i].exp_addr);
      chk("rd_instr", out_instr, mem_word(tbl[i].exp_addr));
      repeat (3) tick();
    end

    // Redirect during stall with full skid
    out_ready = 1'b0;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h80;
    #1;
    chk("rs_en", 32'(imem_en), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_addr", imem_addr, 32'h80);
    chk("rs_en1", 32'(imem_en), 32'd1);
    tick();
    out_ready = 1'b1;
    tick(); #1;
    chk("rs_pc", out_pc, 32'h80);
    chk("rs_valid3", 32'(out_valid), 32'd1);
    repeat (5) tick();

    // Reset during stall with full skid
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_instr", out_instr, NOP_INSTR);
    chk("rst2_pc", out_pc, 32'h0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_en", 32'(imem_en), 32'd1);
    tick();
    tick(); #1;
    chk("rst2_valid2", 32'(out_valid), 32'd1);
    chk("rst2_pc2", out_pc, 32'h0);
    repeat (4) tick();

    // PC wrap on the second instance
    for (int i = 0; i < 3; i++) begin
      if (i < b_seen.size()) begin
        chk("wrap_pc", b_seen[i], b_exp[i]);
      end else begin
        checks++;
        errors++;
        $display("FAIL wrap_pc: got no pair %0d expected %h", i, b_exp[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
